// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - producer/FIFO write-side bundle for fifo_wr_arbiter
// Ports (slave = arbiter view):
//   req, req_data                  producer requests and packed words (in)
//   gnt, done, busy                grant, per-producer accept pulse, busy (out)
//   fifo_wr_en, fifo_data_in       FIFO write port (out)
//   fifo_full, fifo_wr_ack,
//   fifo_overflow                  FIFO status, ack/overflow one cycle after wr_en (in)
//   ovf_cnt                        saturating failed-write count (out)
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            done;
    logic                          busy;
    logic                          fifo_wr_en;
    logic [FIFO_WIDTH-1:0]         fifo_data_in;
    logic                          fifo_full;
    logic                          fifo_wr_ack;
    logic                          fifo_overflow;
    logic [7:0]                    ovf_cnt;

    modport slave (
        input  req, req_data, fifo_full, fifo_wr_ack, fifo_overflow,
        output gnt, done, busy, fifo_wr_en, fifo_data_in, ovf_cnt
    );

    modport master (
        output req, req_data, fifo_full, fifo_wr_ack, fifo_overflow,
        input  gnt, done, busy, fifo_wr_en, fifo_data_in, ovf_cnt
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter sharing one FIFO write port among NUM_REQ producers
// Ports:
//   clk  clock, posedge
//   rst  asynchronous active-high reset
//   bus  fifo_wr_arbiter_if.slave: requests/words in, grant/done/busy out,
//        FIFO write port out, FIFO full/ack/overflow in, ovf_cnt out
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    fifo_wr_arbiter_if.slave  bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2)    $error("fifo_wr_arbiter: NUM_REQ must be >= 2");
    if (FIFO_DEPTH < 1) $error("fifo_wr_arbiter: FIFO_DEPTH must be >= 1");

    typedef enum logic [1:0] {IDLE, GRANT, WRITE, ACK} state_t;

    state_t                 state;
    logic [NUM_REQ-1:0]     gnt_q;
    logic                   wr_en_q;
    logic [FIFO_WIDTH-1:0]  data_q;
    logic [FIFO_WIDTH-1:0]  word_q;
    logic [IDX_W-1:0]       winner;
    logic [IDX_W-1:0]       last;
    logic [7:0]             ovf_q;

    logic                   pick_found;
    logic [IDX_W-1:0]       pick_idx;

    // Search starts just after the last winner and wraps, so the most recent
    // winner is the lowest priority on the next round.
    always_comb begin
        int cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = (int'(last) + off) % NUM_REQ;
            if (!pick_found && bus.req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gnt_q   <= '0;
            wr_en_q <= 1'b0;
            data_q  <= '0;
            word_q  <= '0;
            winner  <= '0;
            last    <= IDX_W'(NUM_REQ - 1);
            ovf_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        gnt_q  <= NUM_REQ'(1) << pick_idx;
                        winner <= pick_idx;
                        word_q <= bus.req_data[pick_idx*FIFO_WIDTH +: FIFO_WIDTH];
                        state  <= GRANT;
                    end
                end
                GRANT: begin
                    if (!bus.fifo_full) begin
                        wr_en_q <= 1'b1;
                        data_q  <= word_q;
                        state   <= WRITE;
                    end
                end
                WRITE: begin
                    wr_en_q <= 1'b0;
                    state   <= ACK;
                end
                ACK: begin
                    if (bus.fifo_wr_ack) begin
                        last  <= winner;
                        gnt_q <= '0;
                        state <= IDLE;
                    end else begin
                        // Overflowed write: keep the grant and the latched word, retry.
                        if (ovf_q != 8'hFF) ovf_q <= ovf_q + 8'd1;
                        state <= GRANT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // done must coincide with the ack it confirms, so it is decoded from the
    // ACK state and the ack input rather than registered.
    assign bus.done         = (state == ACK && bus.fifo_wr_ack) ? gnt_q : '0;
    assign bus.gnt          = gnt_q;
    assign bus.busy         = (state != IDLE);
    assign bus.fifo_wr_en   = wr_en_q;
    assign bus.fifo_data_in = data_q;
    assign bus.ovf_cnt      = ovf_q;

`ifdef SIM
    a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.gnt));
    a_done_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.done));
    a_wr_en_gnt: assert property (@(posedge clk) disable iff (rst) bus.fifo_wr_en |-> (|bus.gnt));
    a_done_gnt: assert property (@(posedge clk) disable iff (rst) (bus.done & ~bus.gnt) == '0);
    a_no_full_in_write: assert property (@(posedge clk) disable iff (rst) (state == WRITE) |-> !bus.fifo_full);
    a_ack_ovf_excl: assert property (@(posedge clk) disable iff (rst)
        (state == ACK) |-> !(bus.fifo_wr_ack && bus.fifo_overflow));
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed table-driven bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic inject = 1'b0;
    int   total = 0;
    int   bad   = 0;

    fifo_wr_arbiter_if #(.NUM_REQ(4), .FIFO_WIDTH(16)) bus ();

    fifo_wr_arbiter #(.NUM_REQ(4), .FIFO_WIDTH(16), .FIFO_DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // FIFO response model: ack/overflow one cycle after wr_en; inject forces overflow.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.fifo_wr_ack   <= 1'b0;
            bus.fifo_overflow <= 1'b0;
        end else begin
            bus.fifo_wr_ack   <= bus.fifo_wr_en & ~inject;
            bus.fifo_overflow <= bus.fifo_wr_en & inject;
        end
    end

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  exp_gnt;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Called just after a clock edge with the arbiter in IDLE.
    task automatic run_word(input logic [3:0] r, input logic [3:0] g,
                            input logic [15:0] d, input bit drop);
        bus.req = r;
        @(posedge clk); #1;
        chk("gnt", 32'(bus.gnt), 32'(g));
        chk("busy_grant", 32'(bus.busy), 32'd1);
        chk("wr_en_grant", 32'(bus.fifo_wr_en), 32'd0);
        if (drop) bus.req = 4'b0000;
        @(posedge clk); #1;
        chk("wr_en", 32'(bus.fifo_wr_en), 32'd1);
        chk("data", 32'(bus.fifo_data_in), 32'(d));
        @(posedge clk); #1;
        chk("done", 32'(bus.done), 32'(g));
        chk("wr_en_ack", 32'(bus.fifo_wr_en), 32'd0);
        @(posedge clk); #1;
        chk("gnt_idle", 32'(bus.gnt), 32'd0);
        chk("busy_idle", 32'(bus.busy), 32'd0);
        chk("done_idle", 32'(bus.done), 32'd0);
    endtask

    initial begin
        bus.req       = 4'b0000;
        bus.req_data  = {16'h4444, 16'hA5A5, 16'h2222, 16'h1111};
        bus.fifo_full = 1'b0;

        // Round-robin from reset, then mixed patterns; pointer carries across rows.
        vecs[0]  = '{4'b1111, 4'b0001, 16'h1111};
        vecs[1]  = '{4'b1111, 4'b0010, 16'h2222};
        vecs[2]  = '{4'b1111, 4'b0100, 16'hA5A5};
        vecs[3]  = '{4'b1111, 4'b1000, 16'h4444};
        vecs[4]  = '{4'b1111, 4'b0001, 16'h1111};
        vecs[5]  = '{4'b1111, 4'b0010, 16'h2222};
        vecs[6]  = '{4'b1111, 4'b0100, 16'hA5A5};
        vecs[7]  = '{4'b1111, 4'b1000, 16'h4444};
        vecs[8]  = '{4'b0100, 4'b0100, 16'hA5A5};
        vecs[9]  = '{4'b1001, 4'b1000, 16'h4444};
        vecs[10] = '{4'b1001, 4'b0001, 16'h1111};
        vecs[11] = '{4'b0110, 4'b0010, 16'h2222};
        vecs[12] = '{4'b1010, 4'b1000, 16'h4444};
        vecs[13] = '{4'b0011, 4'b0001, 16'h1111};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
        chk("rst_data", 32'(bus.fifo_data_in), 32'd0);
        chk("rst_ovf", 32'(bus.ovf_cnt), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++)
            run_word(vecs[i].req, vecs[i].exp_gnt, vecs[i].exp_data, 1'b0);

        // Full stall: grant held, no write while full.
        bus.fifo_full = 1'b1;
        bus.req = 4'b0001;
        @(posedge clk); #1;
        chk("full_gnt", 32'(bus.gnt), 32'b0001);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("full_gnt_hold", 32'(bus.gnt), 32'b0001);
            chk("full_no_wr", 32'(bus.fifo_wr_en), 32'd0);
        end
        bus.fifo_full = 1'b0;
        @(posedge clk); #1;
        chk("full_rel_wr", 32'(bus.fifo_wr_en), 32'd1);
        chk("full_rel_data", 32'(bus.fifo_data_in), 32'h1111);
        @(posedge clk); #1;
        chk("full_rel_done", 32'(bus.done), 32'b0001);
        @(posedge clk); #1;
        chk("full_rel_idle", 32'(bus.busy), 32'd0);
        bus.req = 4'b0000;

        // Overflow once, then retry of the same word.
        bus.req = 4'b0010;
        @(posedge clk); #1;
        chk("ovf_gnt", 32'(bus.gnt), 32'b0010);
        inject = 1'b1;
        @(posedge clk); #1;
        chk("ovf_wr1", 32'(bus.fifo_wr_en), 32'd1);
        @(posedge clk); #1;
        chk("ovf_no_done", 32'(bus.done), 32'd0);
        inject = 1'b0;
        bus.req = 4'b0000;
        @(posedge clk); #1;
        chk("ovf_cnt1", 32'(bus.ovf_cnt), 32'd1);
        chk("ovf_gnt_kept", 32'(bus.gnt), 32'b0010);
        @(posedge clk); #1;
        chk("ovf_wr2", 32'(bus.fifo_wr_en), 32'd1);
        chk("ovf_data2", 32'(bus.fifo_data_in), 32'h2222);
        @(posedge clk); #1;
        chk("ovf_done", 32'(bus.done), 32'b0010);
        @(posedge clk); #1;
        chk("ovf_idle", 32'(bus.busy), 32'd0);
        chk("ovf_cnt_keep", 32'(bus.ovf_cnt), 32'd1);

        // Reset during WRITE.
        bus.req = 4'b0100;
        @(posedge clk); #1;
        chk("mr_gnt", 32'(bus.gnt), 32'b0100);
        @(posedge clk); #1;
        chk("mr_wr", 32'(bus.fifo_wr_en), 32'd1);
        rst = 1'b1;
        #1;
        chk("mr_gnt0", 32'(bus.gnt), 32'd0);
        chk("mr_wr0", 32'(bus.fifo_wr_en), 32'd0);
        chk("mr_data0", 32'(bus.fifo_data_in), 32'd0);
        chk("mr_busy0", 32'(bus.busy), 32'd0);
        chk("mr_done0", 32'(bus.done), 32'd0);
        chk("mr_ovf0", 32'(bus.ovf_cnt), 32'd0);
        #1;
        rst = 1'b0;
        run_word(4'b1111, 4'b0001, 16'h1111, 1'b0);

        // Request dropped after grant: word still written.
        run_word(4'b0010, 4'b0010, 16'h2222, 1'b1);

        // No request: stays idle, pointer unchanged.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("idle_gnt", 32'(bus.gnt), 32'd0);
            chk("idle_wr", 32'(bus.fifo_wr_en), 32'd0);
            chk("idle_busy", 32'(bus.busy), 32'd0);
        end
        run_word(4'b1111, 4'b0100, 16'hA5A5, 1'b0);
        bus.req = 4'b0000;
        @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
